// File: rtl/alu_dsp_dual.sv
// Dual-channel DSP multiply-add responder: three register stages per channel,
// shared opcode, sticky signed-overflow flags, P feedback for accumulation.
module alu_dsp_dual #(
    parameter int AW = 18,
    parameter int PW = 48
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [7:0]    dsp_op,
    input  logic [AW-1:0] dsp_al,
    input  logic [AW-1:0] dsp_bl,
    input  logic [PW-1:0] dsp_cl,
    input  logic [AW-1:0] dsp_ar,
    input  logic [AW-1:0] dsp_br,
    input  logic [PW-1:0] dsp_cr,
    input  logic          ovf_clr,
    output logic [PW-1:0] dsp_pl,
    output logic [PW-1:0] dsp_pr,
    output logic          p_valid,
    output logic          ovf_l,
    output logic          ovf_r
);

    localparam int MW = 2 * AW;

    // Stage 1: captured command
    logic [4:0]    op1_q;
    logic          v1_q;
    logic [AW-1:0] al1_q, bl1_q, ar1_q, br1_q;
    logic [PW-1:0] cl1_q, cr1_q;

    // Stage 2: product plus delayed operands
    logic [4:0]    op2_q;
    logic          v2_q;
    logic [AW-1:0] al2_q, ar2_q;
    logic [PW-1:0] cl2_q, cr2_q;
    logic [PW-1:0] ml2_q, mr2_q;
    logic [PW-1:0] ml2_d, mr2_d;

    // Stage 3: result registers
    logic [PW-1:0] pl_q, pr_q, pl_d, pr_d;
    logic          pv_q, pv_d;
    logic          ovl_q, ovr_q, ovl_d, ovr_d;

    logic signed [MW-1:0] prod_l, prod_r;
    logic [PW-1:0]        sum_l, sum_r;
    logic                 ovf_new_l, ovf_new_r;

    // X/Z mux, add or subtract, and signed overflow for one channel.
    // Returned as {overflow, result}.
    function automatic logic [PW:0] mac(
        input logic [4:0]    op,
        input logic [AW-1:0] a,
        input logic [PW-1:0] m,
        input logic [PW-1:0] c,
        input logic [PW-1:0] p
    );
        logic [PW-1:0] x;
        logic [PW-1:0] z;
        logic [PW-1:0] r;
        logic          ov;
        case (op[1:0])
            2'b01:   x = m;
            2'b10:   x = {{(PW-AW){a[AW-1]}}, a};
            default: x = '0;
        endcase
        case (op[3:2])
            2'b01:   z = c;
            2'b10:   z = p;
            default: z = '0;
        endcase
        if (op[4]) begin
            r  = z - x;
            ov = (z[PW-1] != x[PW-1]) && (r[PW-1] != z[PW-1]);
        end else begin
            r  = z + x;
            ov = (z[PW-1] == x[PW-1]) && (r[PW-1] != z[PW-1]);
        end
        return {ov, r};
    endfunction

    always_comb begin
        prod_l = $signed(al1_q) * $signed(bl1_q);
        prod_r = $signed(ar1_q) * $signed(br1_q);
        ml2_d  = {{(PW-MW){prod_l[MW-1]}}, prod_l};
        mr2_d  = {{(PW-MW){prod_r[MW-1]}}, prod_r};
    end

    always_comb begin
        {ovf_new_l, sum_l} = mac(op2_q, al2_q, ml2_q, cl2_q, pl_q);
        {ovf_new_r, sum_r} = mac(op2_q, ar2_q, mr2_q, cr2_q, pr_q);
        pv_d  = v2_q;
        pl_d  = v2_q ? sum_l : pl_q;
        pr_d  = v2_q ? sum_r : pr_q;
        // A fresh overflow takes priority over a clear in the same cycle.
        ovl_d = (ovl_q & ~ovf_clr) | (v2_q & ovf_new_l);
        ovr_d = (ovr_q & ~ovf_clr) | (v2_q & ovf_new_r);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op1_q <= '0;
            v1_q  <= 1'b0;
            al1_q <= '0;
            bl1_q <= '0;
            ar1_q <= '0;
            br1_q <= '0;
            cl1_q <= '0;
            cr1_q <= '0;
            op2_q <= '0;
            v2_q  <= 1'b0;
            al2_q <= '0;
            ar2_q <= '0;
            cl2_q <= '0;
            cr2_q <= '0;
            ml2_q <= '0;
            mr2_q <= '0;
            pl_q  <= '0;
            pr_q  <= '0;
            pv_q  <= 1'b0;
            ovl_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            op1_q <= dsp_op[4:0];
            v1_q  <= (dsp_op != 8'h00);
            al1_q <= dsp_al;
            bl1_q <= dsp_bl;
            ar1_q <= dsp_ar;
            br1_q <= dsp_br;
            cl1_q <= dsp_cl;
            cr1_q <= dsp_cr;

            op2_q <= op1_q;
            v2_q  <= v1_q;
            al2_q <= al1_q;
            ar2_q <= ar1_q;
            cl2_q <= cl1_q;
            cr2_q <= cr1_q;
            ml2_q <= ml2_d;
            mr2_q <= mr2_d;

            pl_q  <= pl_d;
            pr_q  <= pr_d;
            pv_q  <= pv_d;
            ovl_q <= ovl_d;
            ovr_q <= ovr_d;
        end
    end

    assign dsp_pl  = pl_q;
    assign dsp_pr  = pr_q;
    assign p_valid = pv_q;
    assign ovf_l   = ovl_q;
    assign ovf_r   = ovr_q;

endmodule

// File: tb/tb_alu_dsp_dual.sv
// Bench for alu_dsp_dual: directed literal checks plus randomized traffic
// compared every cycle against an exact-integer reference model.
module tb_alu_dsp_dual;

    localparam logic [7:0] XM  = 8'h01;
    localparam logic [7:0] XA  = 8'h02;
    localparam logic [7:0] ZC  = 8'h04;
    localparam logic [7:0] ZP  = 8'h08;
    localparam logic [7:0] SUB = 8'h10;
    localparam longint MAXP = (longint'(1) <<< 47) - 1;
    localparam longint MINP = -(longint'(1) <<< 47);

    logic        clk, reset_n, ovf_clr;
    logic [7:0]  dsp_op;
    logic [17:0] dsp_al, dsp_bl, dsp_ar, dsp_br;
    logic [47:0] dsp_cl, dsp_cr, dsp_pl, dsp_pr;
    logic        p_valid, ovf_l, ovf_r;

    int n_cmp = 0;
    int n_mis = 0;

    alu_dsp_dual #(.AW(18), .PW(48)) dut (
        .clk(clk), .reset_n(reset_n), .dsp_op(dsp_op),
        .dsp_al(dsp_al), .dsp_bl(dsp_bl), .dsp_cl(dsp_cl),
        .dsp_ar(dsp_ar), .dsp_br(dsp_br), .dsp_cr(dsp_cr),
        .ovf_clr(ovf_clr), .dsp_pl(dsp_pl), .dsp_pr(dsp_pr),
        .p_valid(p_valid), .ovf_l(ovf_l), .ovf_r(ovf_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0]  op;
        logic [17:0] al, bl, ar, br;
        logic [47:0] cl, cr;
    } cmd_t;

    cmd_t        mq[$];
    cmd_t        mc;
    logic [47:0] exp_pl, exp_pr;
    bit          exp_pv, exp_ol, exp_or, mov_l, mov_r;

    function automatic void ref_mac(input logic [7:0] op, input logic [17:0] a, b,
                                    input logic [47:0] c, p_in,
                                    output logic [47:0] p_out, output bit ov);
        longint x, z, s;
        x = 0;
        z = 0;
        if (op[1:0] == 2'b01) x = longint'($signed(a)) * longint'($signed(b));
        else if (op[1:0] == 2'b10) x = longint'($signed(a));
        if (op[3:2] == 2'b01) z = longint'($signed(c));
        else if (op[3:2] == 2'b10) z = longint'($signed(p_in));
        s = op[4] ? z - x : z + x;
        ov = (s > MAXP) || (s < MINP);
        p_out = s[47:0];
    endfunction

    // A command sampled at one edge lands in P two edges later.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            exp_pl = '0; exp_pr = '0;
            exp_pv = 0; exp_ol = 0; exp_or = 0;
        end else begin
            mq.push_back('{dsp_op, dsp_al, dsp_bl, dsp_ar, dsp_br, dsp_cl, dsp_cr});
            mov_l = 0;
            mov_r = 0;
            exp_pv = 0;
            if (mq.size() == 3) begin
                mc = mq.pop_front();
                if (mc.op != 8'h00) begin
                    ref_mac(mc.op, mc.al, mc.bl, mc.cl, exp_pl, exp_pl, mov_l);
                    ref_mac(mc.op, mc.ar, mc.br, mc.cr, exp_pr, exp_pr, mov_r);
                    exp_pv = 1;
                end
            end
            exp_ol = (exp_ol && !ovf_clr) || mov_l;
            exp_or = (exp_or && !ovf_clr) || mov_r;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_pl", 64'(dsp_pl), 64'(exp_pl));
        chk("model_pr", 64'(dsp_pr), 64'(exp_pr));
        chk("model_pv", 64'(p_valid), 64'(exp_pv));
        chk("model_ovf_l", 64'(ovf_l), 64'(exp_ol));
        chk("model_ovf_r", 64'(ovf_r), 64'(exp_or));
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic [7:0] op, input logic [17:0] al, bl, input logic [47:0] cl,
                       input logic [17:0] ar, br, input logic [47:0] cr, input logic clr);
        @(negedge clk);
        dsp_op = op; dsp_al = al; dsp_bl = bl; dsp_cl = cl;
        dsp_ar = ar; dsp_br = br; dsp_cr = cr; ovf_clr = clr;
    endtask

    task automatic nop(input logic clr);
        cyc(8'h00, '0, '0, '0, '0, '0, '0, clr);
    endtask

    initial begin
        reset_n = 1'b0;
        dsp_op = '0; dsp_al = '0; dsp_bl = '0; dsp_cl = '0;
        dsp_ar = '0; dsp_br = '0; dsp_cr = '0; ovf_clr = 1'b0;
        nop(0);
        chk("rst_pl", 64'(dsp_pl), 64'h0);
        chk("rst_pv", 64'(p_valid), 64'h0);
        nop(0);
        reset_n = 1'b1;

        // multiply 1.0 * 0.5
        cyc(XM, 18'h10000, 18'h08000, '0, '0, '0, '0, 0);
        nop(0); chk("mul_pv_c1", 64'(p_valid), 64'h0);
        nop(0); chk("mul_pv_c2", 64'(p_valid), 64'h0);
        nop(0); chk("mul_pl", 64'(dsp_pl), 64'h0000_8000_0000);
        chk("mul_pv_c3", 64'(p_valid), 64'h1);

        // multiply-add with C, independent right channel
        cyc(XM | ZC, 18'h10000, 18'h3FFFF, 48'h1_0000_0000, 18'h00002, 18'h00003, 48'h10, 0);
        nop(0); nop(0); nop(0);
        chk("madd_pl", 64'(dsp_pl), 64'h0000_FFFF_0000);
        chk("madd_pr", 64'(dsp_pr), 64'h16);

        // accumulate chain 1.0*1.0 four times
        cyc(XM, 18'h10000, 18'h10000, '0, '0, '0, '0, 0);
        cyc(XM | ZP, 18'h10000, 18'h10000, '0, '0, '0, '0, 0);
        cyc(XM | ZP, 18'h10000, 18'h10000, '0, '0, '0, '0, 0);
        cyc(XM | ZP, 18'h10000, 18'h10000, '0, '0, '0, '0, 0);
        chk("acc_p1", 64'(dsp_pl), 64'h0001_0000_0000);
        nop(0); chk("acc_p2", 64'(dsp_pl), 64'h0002_0000_0000);
        nop(0); chk("acc_p3", 64'(dsp_pl), 64'h0003_0000_0000);
        nop(0); chk("acc_p4", 64'(dsp_pl), 64'h0004_0000_0000);
        chk("acc_pv4", 64'(p_valid), 64'h1);

        // NOP hold then subtract
        cyc(XA, 18'h00005, '0, '0, '0, '0, '0, 0);
        nop(0); nop(0); nop(0);
        chk("hold_p5", 64'(dsp_pl), 64'h5);
        for (int i = 0; i < 4; i++) begin
            nop(0);
            chk("hold_pl", 64'(dsp_pl), 64'h5);
            chk("hold_pv", 64'(p_valid), 64'h0);
        end
        cyc(XA | ZP | SUB, 18'h00001, '0, '0, '0, '0, '0, 0);
        nop(0); nop(0); nop(0);
        chk("sub_pl", 64'(dsp_pl), 64'h4);

        // overflow, sticky, clear, set-wins
        cyc(XA | ZC, 18'h00001, '0, 48'h7FFF_FFFF_FFFF, '0, '0, '0, 0);
        nop(0); nop(0); nop(0);
        chk("ovf_pl", 64'(dsp_pl), 64'h8000_0000_0000);
        chk("ovf_set", 64'(ovf_l), 64'h1);
        nop(0); chk("ovf_sticky", 64'(ovf_l), 64'h1);
        nop(1); nop(0); chk("ovf_cleared", 64'(ovf_l), 64'h0);
        cyc(XA | ZC, 18'h00001, '0, 48'h7FFF_FFFF_FFFF, '0, '0, '0, 0);
        nop(0); nop(1); nop(0);
        chk("ovf_set_wins", 64'(ovf_l), 64'h1);

        // reset with commands in flight
        cyc(XM, 18'h10000, 18'h10000, '0, 18'h1, 18'h1, '0, 0);
        cyc(XA, 18'h00009, '0, '0, 18'h2, '0, '0, 0);
        cyc(XM | ZP, 18'h10000, 18'h10000, '0, 18'h1, 18'h1, '0, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_pl", 64'(dsp_pl), 64'h0);
        chk("rst_mid_pv", 64'(p_valid), 64'h0);
        chk("rst_mid_ovf", 64'(ovf_l), 64'h0);
        nop(0);
        reset_n = 1'b1;
        cyc(XA, 18'h00007, '0, '0, '0, '0, '0, 0);
        nop(0); chk("post_rst_pv1", 64'(p_valid), 64'h0);
        nop(0); chk("post_rst_pv2", 64'(p_valid), 64'h0);
        nop(0); chk("post_rst_pl", 64'(dsp_pl), 64'h7);
        chk("post_rst_pv3", 64'(p_valid), 64'h1);

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 600; i++) begin
            logic [7:0] op;
            case ($urandom_range(0, 4))
                0:       op = 8'h00;
                1:       op = XM | ZP | 8'($urandom_range(0, 1) << 4);
                default: op = 8'($urandom);
            endcase
            cyc(op, 18'($urandom), 18'($urandom), 48'({$urandom, $urandom}),
                18'($urandom), 18'($urandom), 48'({$urandom, $urandom}),
                ($urandom_range(0, 9) == 0));
        end
        nop(0); nop(0); nop(0); nop(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
